// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//
// Multi-cycle multiply/divide unit that sits right after the register bank.
// It takes the two read-data words (A from DR1, B from DR2), runs a radix-2
// shift-add multiply or restoring divide over WIDTH iterations, then applies
// sign correction and writes the HI/LO result registers. HI/LO can also be
// written directly (MTHI/MTLO) while the unit is idle.
//
// Ports:
//   clk    in   1      clock, all state updates on rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      launch an operation (sampled only while idle)
//   op     in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A      in   WIDTH  multiplicand / dividend (rs)
//   B      in   WIDTH  multiplier / divisor (rt)
//   wr_hi  in   1      MTHI write enable (idle only)
//   wr_lo  in   1      MTLO write enable (idle only)
//   wdata  in   WIDTH  MTHI/MTLO write data
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse after HI/LO receive a result
//   HI     out  WIDTH  product high half / remainder
//   LO     out  WIDTH  product low half / quotient
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rawA_q, rawA_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               isDiv_q, isDiv_d;
    logic               negLo_q, negLo_d;
    logic               negHi_q, negHi_d;
    logic               divZero_q, divZero_d;
    logic               done_q, done_d;

    // Operand magnitudes and sign bits used when an operation is launched.
    // Only the signed ops (op[0]=1) take absolute values.
    logic               signA, signB;
    logic [WIDTH-1:0]   absA, absB;

    assign signA = op[0] & A[WIDTH-1];
    assign signB = op[0] & B[WIDTH-1];
    assign absA  = signA ? (~A + 1'b1) : A;
    assign absB  = signB ? (~B + 1'b1) : B;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit (acc LSB) is set; the carry becomes the new MSB
    // after the right shift.
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     mulUpper;

    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign mulUpper = acc_q[0] ? mulSum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    // Divide step: shift the next dividend bit into a WIDTH+1-bit partial
    // remainder and trial-subtract the divisor; a borrow (MSB set) means the
    // subtraction is discarded and the quotient bit is 0.
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;

    assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, mcand_q};

    // Sign-corrected results, only consumed in the FIX state.
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    assign prodFix = negLo_q ? (~acc_q + 1'b1) : acc_q;
    assign quotFix = negLo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign remFix  = negHi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                             : acc_q[2*WIDTH-1:WIDTH];

    // Next-state and datapath logic. Every register holds by default; each
    // state only overrides what it changes. While busy, start and the
    // MTHI/MTLO enables are simply not looked at.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        rawA_d    = rawA_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        isDiv_d   = isDiv_q;
        negLo_d   = negLo_q;
        negHi_d   = negHi_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    isDiv_d   = op[1];
                    negLo_d   = signA ^ signB;
                    negHi_d   = op[1] ? signA : (signA ^ signB);
                    divZero_d = op[1] && (B == '0);
                    rawA_d    = A;
                    cnt_d     = '0;
                    state_d   = RUN;
                    // Multiply: multiplier in the low half, multiplicand aside.
                    // Divide: dividend in the low half, divisor aside.
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, absA};
                        mcand_d = absB;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, absB};
                        mcand_d = absA;
                    end
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end

            RUN: begin
                if (isDiv_q) begin
                    if (divDiff[WIDTH]) begin
                        acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mulUpper, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FIX: begin
                if (!isDiv_q) begin
                    hi_d = prodFix[2*WIDTH-1:WIDTH];
                    lo_d = prodFix[WIDTH-1:0];
                end else if (divZero_q) begin
                    // Divide by zero: quotient all ones, HI gets the raw dividend.
                    hi_d = rawA_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = remFix;
                    lo_d = quotFix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything immediately, so
    // an aborted operation never leaks a partial result into HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rawA_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            rawA_q    <= rawA_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            isDiv_q   <= isDiv_d;
            negLo_q   <= negLo_d;
            negHi_q   <= negHi_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit directly downstream of the register bank.
- Consumes the two read-data words (DR1 → A, DR2 → B) for MULT, MULTU, DIV and DIVU.
- Holds the HI/LO result registers and supports MTHI/MTLO writes.
- Execution is a radix-2 shift-add / restoring-divide datapath; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  launch operation; sampled on clk rise.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  rs operand (from DR1): multiplicand or dividend.
- B  input  WIDTH  rt operand (from DR2): multiplier or divisor.
- wr_hi  input  1  MTHI write enable.
- wr_lo  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- HI  output  WIDTH  HI register (product high / remainder).
- LO  output  WIDTH  LO register (product low / quotient).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; HI=0, LO=0, busy=0, done=0; counter and internal registers cleared.
  - Asserting rst_n low mid-operation aborts immediately; no partial result reaches HI/LO.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: latch op, A and B.
    - Signed ops latch |A|, |B| and sign bits (MULT: sA^sB; DIV: quotient sA^sB, remainder sA).
    - Set busy=1, counter=0, go to RUN.
  - Else wr_hi=1 writes HI<=wdata; wr_lo=1 writes LO<=wdata; both may fire on the same edge.
  - start has priority: if start=1, any wr_hi/wr_lo on that edge is dropped.
- RUN:
  - One iteration per edge, E1..E32; transition to FIX on E32 (counter==WIDTH-1).
  - Multiply: 2*WIDTH-bit shift-add accumulator.
  - Divide: restoring algorithm with a WIDTH+1-bit partial remainder.
  - start, wr_hi and wr_lo are ignored while busy=1.
  - HI/LO hold their previous values throughout.
- FIX, one edge (E33):
  - Apply sign correction (two's-complement negate where the sign bit is 1).
  - Write HI/LO; busy<=0, done<=1, go to IDLE.
  - Latency: start edge to HI/LO valid = 33 clocks; done is high exactly for the cycle following E33.
  - done clears on the next edge regardless of inputs.
  - A start on that next edge is accepted, giving back-to-back operation.
- Arithmetic rules:
  - MULTU: {HI,LO}=A*B unsigned.
  - MULT: {HI,LO}=A*B signed.
  - DIVU: LO=A/B, HI=A%B unsigned.
  - DIV: truncate toward zero; remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU, B=0):
  - LO=all ones, HI=A exactly as latched (unsigned raw).
  - Full 33-clock latency, done pulses normally.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap, no flag.
- Operands are captured at the start edge; changes on A/B during RUN have no effect.

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → busy high 33 cycles, done pulse once, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Then back-to-back start on the done cycle+1: DIVU A=100, B=7 → LO=0x0000000E, HI=0x00000002.
- DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU A=5, B=0 → LO=0xFFFFFFFF, HI=0x00000005.
- Idle wr_lo=1, wdata=0x12345678 → LO=0x12345678 next edge.
  - wr_hi during busy → HI unchanged.
  - start during busy → ignored; result matches first op.
  - start+wr_hi same edge → HI write dropped.
- Pull rst_n low asynchronously at cycle 10 of a MULT → busy, done, HI and LO go to 0 without a clock edge.
  - After release, MULTU 3*4 → LO=12, HI=0.
